// File: rtl/gnrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gnrl_pkg
// Description : Shared sizing helpers for the general-purpose FIFO family.
//               ptr_width : index width for a DP-entry ring, at least 1 bit
//               cnt_width : width able to hold an occupancy of 0..DP
// Revision    : 1.0 - initial release
// ============================================================================
package gnrl_pkg;

    // A single-entry FIFO still carries a 1-bit pointer so that every
    // vector in the datapath has a legal, non-zero width.
    function automatic int ptr_width(input int dp);
        return (dp > 1) ? $clog2(dp) : 1;
    endfunction

    // Occupancy must reach DP itself, hence DP+1 distinct values.
    function automatic int cnt_width(input int dp);
        return $clog2(dp + 1);
    endfunction

endpackage : gnrl_pkg
`default_nettype wire

// File: rtl/fifo_ent_reg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ent_reg
// Description : One FIFO storage entry. DW-bit register that loads d when ld
//               is high and clears to zero on asynchronous reset.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low clear
//               ld    - load enable
//               d     - data in  [DW-1:0]
//               q     - data out [DW-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ent_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : fifo_ent_reg
`default_nettype wire

// File: rtl/gnrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gnrl_sync_fifo
// Description : Synchronous valid/ready FIFO, DP entries of DW bits.
//               Occupancy counter is the sole source of full/empty, so the
//               read and write pointers wrap independently without any
//               equality ambiguity. No fall-through: a word pushed into an
//               empty FIFO is presented on o_dat the cycle after the push.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               i_vld / i_rdy / i_dat - producer handshake and write data
//               o_vld / o_rdy / o_dat - consumer handshake and head data
//               cnt   - occupancy 0..DP
//               full  - cnt == DP
//               empty - cnt == 0
// Revision    : 1.0 - initial release
// ============================================================================
module gnrl_sync_fifo
    import gnrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int DP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vld,
    output logic                     i_rdy,
    input  logic [DW-1:0]            i_dat,
    output logic                     o_vld,
    input  logic                     o_rdy,
    output logic [DW-1:0]            o_dat,
    output logic [cnt_width(DP)-1:0] cnt,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = ptr_width(DP);
    localparam int CW = cnt_width(DP);

    localparam logic [PW-1:0] C_PTR_LAST = PW'(DP - 1);
    localparam logic [PW-1:0] C_PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] C_CNT_FULL = CW'(DP);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [DW-1:0] w_ent_q [DP];

    // Handshake readiness comes only from the registered count, keeping
    // i_vld and o_rdy off any combinational path to i_rdy / o_vld.
    assign w_full  = (r_cnt == C_CNT_FULL);
    assign w_empty = (r_cnt == '0);

    assign w_push  = i_vld & ~w_full;
    assign w_pop   = o_rdy & ~w_empty;

    // Ring advance; DP need not be a power of two, so wrap explicitly.
    assign w_wptr_nxt = (r_wptr == C_PTR_LAST) ? '0 : (r_wptr + C_PTR_ONE);
    assign w_rptr_nxt = (r_rptr == C_PTR_LAST) ? '0 : (r_rptr + C_PTR_ONE);

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + C_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - C_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: one load-enabled register per entry. Entries are only
    // written on push; a pop merely moves the read pointer.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DP; gi++) begin : g_ent
        logic w_ld;

        assign w_ld = w_push & (r_wptr == PW'(gi));

        fifo_ent_reg #(
            .DW (DW)
        ) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (w_ld),
            .d     (i_dat),
            .q     (w_ent_q[gi])
        );
    end

    // ------------------------------------------------------------------
    // Head-of-queue read mux. Written as a decoded select so that pointer
    // codes beyond DP-1 (non-power-of-two depths) simply yield zero.
    // ------------------------------------------------------------------
    always_comb begin
        o_dat = '0;
        for (int i = 0; i < DP; i++) begin
            if (r_rptr == PW'(i)) begin
                o_dat = w_ent_q[i];
            end
        end
    end

    assign i_rdy = ~w_full;
    assign o_vld = ~w_empty;
    assign cnt   = r_cnt;
    assign full  = w_full;
    assign empty = w_empty;

endmodule : gnrl_sync_fifo
`default_nettype wire

// File: tb/tb_gnrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnrl_sync_fifo
// Description : Directed self-checking bench for gnrl_sync_fifo, one DP=4
//               instance and one DP=1 instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gnrl_sync_fifo;

    logic        clk;
    logic        rst_n;

    // DP = 4 instance
    logic        vld;
    logic        irdy;
    logic [31:0] dat;
    logic        ovld;
    logic        rdy;
    logic [31:0] odat;
    logic [2:0]  cnt;
    logic        full;
    logic        empty;

    // DP = 1 instance
    logic        vld1;
    logic        irdy1;
    logic [31:0] dat1;
    logic        ovld1;
    logic        rdy1;
    logic [31:0] odat1;
    logic [0:0]  cnt1;
    logic        full1;
    logic        empty1;

    int n_cmp;
    int n_fail;

    gnrl_sync_fifo #(.DW(32), .DP(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (vld),
        .i_rdy (irdy),
        .i_dat (dat),
        .o_vld (ovld),
        .o_rdy (rdy),
        .o_dat (odat),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    gnrl_sync_fifo #(.DW(32), .DP(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (vld1),
        .i_rdy (irdy1),
        .i_dat (dat1),
        .o_vld (ovld1),
        .o_rdy (rdy1),
        .o_dat (odat1),
        .cnt   (cnt1),
        .full  (full1),
        .empty (empty1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of the DP=4 instance status outputs.
    task automatic chk_st(input string tag, input logic v, input logic r,
                          input logic [2:0] c, input logic f, input logic e);
        chk({tag, ".o_vld"}, 64'(ovld), 64'(v));
        chk({tag, ".i_rdy"}, 64'(irdy), 64'(r));
        chk({tag, ".cnt"},   64'(cnt),  64'(c));
        chk({tag, ".full"},  64'(full), 64'(f));
        chk({tag, ".empty"}, 64'(empty), 64'(e));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        vld    = 1'b0; rdy  = 1'b0; dat  = '0;
        vld1   = 1'b0; rdy1 = 1'b0; dat1 = '0;

        // ---------------- reset then idle ----------------
        cyc(); cyc();
        rst_n = 1'b1;
        chk_st("rst", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        chk("rst.o_dat", 64'(odat), 64'h0);
        chk("rst1.empty", 64'(empty1), 64'h1);

        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_st("idle", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        end
        chk("idle.o_dat", 64'(odat), 64'h0);

        // ---------------- fill then drain ----------------
        rdy = 1'b0; vld = 1'b1;
        dat = 32'h11; cyc();
        chk_st("fill1", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("fill1.o_dat", 64'(odat), 64'h11);
        dat = 32'h22; cyc();
        chk("fill2.cnt", 64'(cnt), 64'd2);
        dat = 32'h33; cyc();
        chk("fill3.cnt", 64'(cnt), 64'd3);
        dat = 32'h44; cyc();
        chk_st("fill4", 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        chk("fill4.o_dat", 64'(odat), 64'h11);

        dat = 32'h55;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("refuse.cnt", 64'(cnt), 64'd4);
            chk("refuse.o_dat", 64'(odat), 64'h11);
        end

        vld = 1'b0; rdy = 1'b1;
        chk("drain0.o_dat", 64'(odat), 64'h11);
        cyc();
        chk("drain1.o_dat", 64'(odat), 64'h22);
        chk("drain1.cnt", 64'(cnt), 64'd3);
        cyc();
        chk("drain2.o_dat", 64'(odat), 64'h33);
        cyc();
        chk("drain3.o_dat", 64'(odat), 64'h44);
        chk("drain3.cnt", 64'(cnt), 64'd1);
        cyc();
        chk_st("drained", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);

        // ---------------- streaming with wrap ----------------
        vld = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            dat = 32'(k);
            if (k > 0) begin
                chk("stream.o_vld", 64'(ovld), 64'h1);
                chk("stream.o_dat", 64'(odat), 64'(k - 1));
            end
            cyc();
            chk("stream.cnt", 64'(cnt), 64'd1);
        end
        chk("stream.last", 64'(odat), 64'd19);

        // ---------------- full plus simultaneous pop ----------------
        rdy = 1'b0;
        dat = 32'hA0; cyc();
        dat = 32'hA1; cyc();
        dat = 32'hA2; cyc();
        chk_st("refill", 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        chk("refill.o_dat", 64'(odat), 64'd19);
        dat = 32'hA3; rdy = 1'b1;
        cyc();
        chk("fullpop.cnt", 64'(cnt), 64'd3);
        chk("fullpop.o_dat", 64'(odat), 64'hA0);
        cyc();
        chk("pushpop.cnt", 64'(cnt), 64'd3);
        chk("pushpop.o_dat", 64'(odat), 64'hA1);
        vld = 1'b0;
        cyc();
        chk("pre_rst.cnt", 64'(cnt), 64'd2);
        chk("pre_rst.o_dat", 64'(odat), 64'hA2);

        // ---------------- reset mid-operation ----------------
        vld = 1'b1; rdy = 1'b1; dat = 32'h77;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        chk("async_rst.o_dat", 64'(odat), 64'h0);
        cyc();
        chk("in_rst.cnt", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        rdy = 1'b0; dat = 32'hA5;
        cyc();
        chk_st("post_rst", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("post_rst.o_dat", 64'(odat), 64'hA5);
        vld = 1'b0;

        // ---------------- DP = 1 instance ----------------
        vld1 = 1'b1; rdy1 = 1'b0; dat1 = 32'hDEAD;
        cyc();
        chk("dp1.full", 64'(full1), 64'h1);
        chk("dp1.i_rdy", 64'(irdy1), 64'h0);
        chk("dp1.o_dat", 64'(odat1), 64'hDEAD);
        dat1 = 32'hBEEF; rdy1 = 1'b1;
        cyc();
        chk("dp1_pp.empty", 64'(empty1), 64'h1);
        chk("dp1_pp.cnt", 64'(cnt1), 64'h0);
        rdy1 = 1'b0;
        cyc();
        chk("dp1_beef.o_dat", 64'(odat1), 64'hBEEF);
        chk("dp1_beef.full", 64'(full1), 64'h1);
        vld1 = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_gnrl_sync_fifo
`default_nettype wire

// File: doc/gnrl_sync_fifo.md
# gnrl_sync_fifo

Synchronous valid/ready FIFO: the consuming end paired with the team's load-enabled register cells. A producer pushes DW-bit words on the input handshake. A consumer pops them in order on the output handshake. It decouples pipeline stages in the NPC (fetch-to-decode, LSU response buffering) and holds up to DP words in cleared-on-reset entry registers.

## Interface
- DW, 32, data width in bits (≥1)
- DP, 4, depth in entries (≥1; any integer, power of two not required)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset: asynchronous, active-low
- i_vld  in  1  producer has a word on i_dat
- i_rdy  out  1  FIFO accepts a word this cycle
- i_dat  in  DW  write data
- o_vld  out  1  FIFO has a word on o_dat
- o_rdy  in  1  consumer takes the word this cycle
- o_dat  out  DW  head-of-queue data
- cnt  out  CW  occupancy, 0..DP; CW = $clog2(DP+1)
- full  out  1  cnt == DP
- empty  out  1  cnt == 0

## Operation
- push = i_vld & i_rdy; pop = o_vld & o_rdy.
- i_rdy = !full; o_vld = !empty. Both are derived from registered state only, with no combinational path from i_vld or o_rdy.
- Push: entry[wptr] loads i_dat; wptr advances.
- Pop: rptr advances.
- Pointer advance: ptr == DP-1 → 0, else ptr+1. Pointer width is $clog2(DP), with a minimum of 1 bit.
- cnt: +1 on push only, −1 on pop only, unchanged on both or neither.
- o_dat = entry[rptr], a combinational read mux over registered entries.
- Entries are written only on push (load enable). They are not cleared on pop.
- No fall-through path: a word pushed while empty appears on o_dat the cycle after the push.
- Boundaries:
  - Full: i_rdy = 0, so no push, even if a pop occurs in the same cycle.
  - Empty: o_vld = 0. o_rdy is ignored and cnt does not underflow.
  - Push and pop in the same cycle, 0 < cnt < DP: both pointers advance and cnt is unchanged.
  - Wrap-around: pointers wrap independently, and cnt alone determines full/empty (no pointer-equality ambiguity).
  - DP = 1: alternates between full and empty; there is no same-cycle push and pop.
  - i_vld while full: no state change. The producer must hold i_dat until i_rdy.
- Output stability: while o_vld = 1 and no pop, o_dat is stable.
- Reset (asynchronous, any time, including mid-transfer):
  - wptr = rptr = 0, cnt = 0, all entries = 0.
  - Outputs immediately: o_vld = 0, i_rdy = 1, full = 0, empty = 1, o_dat = 0.
  - Any in-flight handshake in the reset cycle is discarded.
  - On rst_n release, the first push may occur at the first rising edge with rst_n = 1.

## Timing
- Write-to-read latency: 1 cycle. A push at edge N gives o_vld = 1 and o_dat valid after edge N.
- Throughput: one push and one pop per cycle while 0 < cnt < DP.
- full, empty and cnt update on the same edge as the causing push or pop.
- i_rdy and o_vld change only after clock edges or on asynchronous reset.
- Critical path: rptr decode → DP:1 mux → o_dat.

## Structure
- Shared package gnrl_pkg holds:
  - the function for pointer width: max(1, $clog2(DP))
  - the function for count width: $clog2(DP+1)
- One natural sub-module, fifo_ent_reg (DW-bit register, load enable, asynchronous active-low clear to 0). It is instantiated DP times via a generate loop.
- Pointer, count and full/empty logic stay in the top module.

## Test plan
- Reset then idle, DW=32, DP=4:
  - → o_vld=0, i_rdy=1, empty=1, cnt=0, o_dat=0.
  - o_rdy=1 for 3 cycles → no change.
- Fill then drain:
  - Push 0x11, 0x22, 0x33, 0x44 back-to-back with o_rdy=0 → full=1, i_rdy=0, cnt=4.
  - A 5th push of 0x55, held 3 cycles, is refused.
  - Then o_rdy=1 → pops 0x11, 0x22, 0x33, 0x44 on consecutive cycles, empty=1 after the 4th.
- Streaming with wrap:
  - i_vld=o_rdy=1 for 20 cycles, data 0..19 → output order 0..19.
  - cnt stays 1 after the first cycle; wptr/rptr wrap 3→0 at least 4 times.
- Full plus simultaneous pop:
  - cnt=4 with i_vld=1 and o_rdy=1 → one pop, no push, cnt=3.
  - Next cycle the push is accepted and cnt=3.
- Reset mid-operation:
  - cnt=2 with a push/pop in flight; assert rst_n low between edges → outputs are reset values before the next edge.
  - After release, push 0xA5 → o_dat=0xA5 one cycle later.
- DP=1 instance:
  - Push 0xDEAD → full=1.
  - Push and pop in the same cycle → only the pop occurs.
  - Push 0xBEEF on the next cycle → o_dat=0xBEEF.
